wb_bram_arbiter: RTL and testbench

//  Shares the single-port FPGA block RAM between two Wishbone-pipelined masters:
//  m0 = hart data port, m1 = loader/debug port. One outstanding transaction at a

---
 rtl/wb_bram_arbiter_pkg.sv | 6 +
 rtl/wb_bram_arbiter_if.sv | 8 +
 rtl/wb_bram_arbiter_select.sv | 22 ++
 rtl/wb_bram_arbiter.sv | 115 +++++++++++
 tb/tb_wb_bram_arbiter.sv | 164 ++++++++++++++++
 5 files changed

// File: rtl/wb_bram_arbiter_pkg.sv
// wb_bram_arbiter_pkg: shared types for the block RAM arbiter (FSM states, master index, watchdog width)
package wb_bram_arbiter_pkg;
  typedef enum logic [1:0] {IDLE, REQ, WAIT} state_t;
  typedef logic mst_t;
  localparam int CNT_W = 8;
endpackage

// File: rtl/wb_bram_arbiter_if.sv
// wb_bram_arbiter_if: one Wishbone-pipelined link (master drives request, slave returns stall/ack/err/data)
interface wb_bram_arbiter_if #(parameter int XLEN = 32, parameter int SELW = 3);
  logic            stb, we, stall, ack, err;
  logic [SELW-1:0] sel;
  logic [XLEN-1:0] addr, wdata, rdata;
  modport master (output stb, we, sel, addr, wdata, input stall, ack, err, rdata);
  modport slave  (input stb, we, sel, addr, wdata, output stall, ack, err, rdata);
endinterface

// File: rtl/wb_bram_arbiter_select.sv
// wb_arb_select: grant policy; fixed m0 priority, or round-robin when WB_ARB_ROUND_ROBIN_EN is defined
module wb_arb_select
  import wb_bram_arbiter_pkg::*;
(
  input  logic stb0_i,
  input  logic stb1_i,
`ifdef WB_ARB_ROUND_ROBIN_EN
  input  mst_t last_i,
`endif
  output logic any_o,
  output mst_t gnt_o
);
  // a lone requester always wins; a tie goes to m0 or to the master not served last
  always_comb begin
    any_o = stb0_i | stb1_i;
`ifdef WB_ARB_ROUND_ROBIN_EN
    gnt_o = (stb0_i && stb1_i) ? mst_t'(~last_i) : mst_t'(~stb0_i);
`else
    gnt_o = mst_t'(~stb0_i);
`endif
  end
endmodule

// File: rtl/wb_bram_arbiter.sv
// wb_bram_arbiter: shares one block RAM between two Wishbone masters with a watchdog; policy via WB_ARB_ROUND_ROBIN_EN
module wb_bram_arbiter
  import wb_bram_arbiter_pkg::*;
#(
  parameter int XLEN    = 32,
  parameter int SELW    = 3,
  parameter int TIMEOUT = 15
) (
  input logic                   i_clk,
  input logic                   i_reset_n,
  wb_bram_arbiter_if.slave      m0,
  wb_bram_arbiter_if.slave      m1,
  wb_bram_arbiter_if.master     s
);
  state_t           state_q;
  mst_t             gnt_q, win;
  logic             any, stb_q, we_q, done, expire;
  logic [SELW-1:0]  sel_q;
  logic [XLEN-1:0]  addr_q, data_q, rd0_q, rd1_q;
  logic [1:0]       ack_q, err_q;
  logic [CNT_W-1:0] cnt_q;
`ifdef WB_ARB_ROUND_ROBIN_EN
  mst_t             last_q;
`endif

  wb_arb_select u_sel (
    .stb0_i (m0.stb),
    .stb1_i (m1.stb),
`ifdef WB_ARB_ROUND_ROBIN_EN
    .last_i (last_q),
`endif
    .any_o  (any),
    .gnt_o  (win)
  );

  // completion needs the RAM to have taken the strobe; ack beats a simultaneous expiry
  always_comb begin
    done   = s.ack && (state_q == WAIT || (state_q == REQ && !s.stall));
    expire = cnt_q == CNT_W'(TIMEOUT - 1);
  end

  // request FSM: accept and latch in IDLE, present in REQ, await ack in WAIT, watchdog abort
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_q <= IDLE;
      gnt_q   <= 1'b0;
      stb_q   <= 1'b0;
      we_q    <= 1'b0;
      sel_q   <= '0;
      addr_q  <= '0;
      data_q  <= '0;
      rd0_q   <= '0;
      rd1_q   <= '0;
      ack_q   <= '0;
      err_q   <= '0;
      cnt_q   <= '0;
`ifdef WB_ARB_ROUND_ROBIN_EN
      last_q  <= 1'b1;
`endif
    end else begin
      ack_q <= '0;
      err_q <= '0;
      case (state_q)
        IDLE: if (any) begin
          state_q <= REQ;
          stb_q   <= 1'b1;
          gnt_q   <= win;
          cnt_q   <= '0;
          we_q    <= win ? m1.we : m0.we;
          sel_q   <= win ? m1.sel : m0.sel;
          addr_q  <= win ? m1.addr : m0.addr;
          data_q  <= win ? m1.wdata : m0.wdata;
`ifdef WB_ARB_ROUND_ROBIN_EN
          last_q  <= win;
`endif
        end
        REQ, WAIT: begin
          cnt_q <= cnt_q + 1'b1;
          if (done) begin
            state_q      <= IDLE;
            stb_q        <= 1'b0;
            ack_q[gnt_q] <= 1'b1;
            if (gnt_q) rd1_q <= s.rdata;
            else rd0_q <= s.rdata;
          end else if (expire) begin
            state_q      <= IDLE;
            stb_q        <= 1'b0;
            err_q[gnt_q] <= 1'b1;
          end else if (state_q == REQ && !s.stall) begin
            state_q <= WAIT;
            stb_q   <= 1'b0;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // only the IDLE-state winner sees stall low; everything stalls while in reset
  always_comb begin
    m0.stall = !(i_reset_n && state_q == IDLE && any && win == 1'b0);
    m1.stall = !(i_reset_n && state_q == IDLE && any && win == 1'b1);
    m0.ack   = ack_q[0];
    m1.ack   = ack_q[1];
    m0.err   = err_q[0];
    m1.err   = err_q[1];
    m0.rdata = rd0_q;
    m1.rdata = rd1_q;
    s.stb    = stb_q;
    s.we     = we_q;
    s.sel    = sel_q;
    s.addr   = addr_q;
    s.wdata  = data_q;
  end
endmodule

// File: tb/tb_wb_bram_arbiter.sv
// tb_wb_bram_arbiter: directed vectors for wb_bram_arbiter (default build, or WB_ARB_ROUND_ROBIN_EN)
module tb_wb_bram_arbiter;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   vec = 0;
  int   miss = 0;

  wb_bram_arbiter_if #(.XLEN(32), .SELW(3)) m0_if ();
  wb_bram_arbiter_if #(.XLEN(32), .SELW(3)) m1_if ();
  wb_bram_arbiter_if #(.XLEN(32), .SELW(3)) s_if ();

  wb_bram_arbiter #(.XLEN(32), .SELW(3), .TIMEOUT(15)) dut (
    .i_clk     (clk),
    .i_reset_n (rst_n),
    .m0        (m0_if.slave),
    .m1        (m1_if.slave),
    .s         (s_if.master)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vec++;
    assert (obs === exp) else begin
      miss++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [31:0] rr_addr [3];

  initial begin
    m0_if.stb = 0; m0_if.we = 0; m0_if.sel = 0; m0_if.addr = 0; m0_if.wdata = 0;
    m1_if.stb = 0; m1_if.we = 0; m1_if.sel = 0; m1_if.addr = 0; m1_if.wdata = 0;
    s_if.stall = 0; s_if.ack = 0; s_if.err = 0; s_if.rdata = 0;
`ifdef WB_ARB_ROUND_ROBIN_EN
    rr_addr[0] = 32'h100; rr_addr[1] = 32'h200; rr_addr[2] = 32'h100;
`else
    rr_addr[0] = 32'h100; rr_addr[1] = 32'h100; rr_addr[2] = 32'h100;
`endif
    #3;
    chk("rst_m0_stall", m0_if.stall, 1);
    chk("rst_m1_stall", m1_if.stall, 1);
    chk("rst_s_stb", s_if.stb, 0);
    chk("rst_m0_ack", m0_if.ack, 0);
    chk("rst_m0_data", m0_if.rdata, 0);
    tick(); tick();
    rst_n = 1;
    tick();

    m0_if.stb = 1; m0_if.addr = 32'h10; m0_if.sel = 3'b100;
    #1;
    chk("t1_m0_stall", m0_if.stall, 0);
    chk("t1_m1_stall", m1_if.stall, 1);
    tick();
    m0_if.stb = 0; m0_if.addr = 32'hFFFF;
    chk("t1_s_stb", s_if.stb, 1);
    chk("t1_s_addr", s_if.addr, 32'h10);
    chk("t1_s_we", s_if.we, 0);
    chk("t1_m0_stall_req", m0_if.stall, 1);
    tick();
    chk("t1_s_stb_drop", s_if.stb, 0);
    s_if.ack = 1; s_if.rdata = 32'hDEADBEEF;
    tick();
    s_if.ack = 0;
    chk("t1_m0_ack", m0_if.ack, 1);
    chk("t1_m0_data", m0_if.rdata, 32'hDEADBEEF);
    chk("t1_m1_ack", m1_if.ack, 0);
    chk("t1_m0_err", m0_if.err, 0);
    tick();
    chk("t1_m0_ack_pulse", m0_if.ack, 0);
    chk("t1_m0_data_hold", m0_if.rdata, 32'hDEADBEEF);

    m0_if.stb = 1; m0_if.addr = 32'h100;
    m1_if.stb = 1; m1_if.addr = 32'h200;
    s_if.ack = 1; s_if.rdata = 32'h0000_0A0A;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("t2_s_stb", s_if.stb, 1);
      chk("t2_s_addr", s_if.addr, rr_addr[k]);
      tick();
      chk("t2_m0_ack", m0_if.ack, rr_addr[k] == 32'h100);
      chk("t2_m1_ack", m1_if.ack, rr_addr[k] == 32'h200);
    end
    m0_if.stb = 0; m1_if.stb = 0; s_if.ack = 0;
    tick();

    m0_if.stb = 1; m0_if.addr = 32'h30; s_if.stall = 1;
    tick();
    m0_if.stb = 0; m0_if.addr = 0;
    for (int i = 0; i < 5; i++) begin
      s_if.stall = (i < 4);
      #1;
      chk("t3_s_stb", s_if.stb, 1);
      chk("t3_s_addr", s_if.addr, 32'h30);
      chk("t3_m0_stall", m0_if.stall, 1);
      chk("t3_m1_stall", m1_if.stall, 1);
      tick();
    end
    chk("t3_s_stb_drop", s_if.stb, 0);
    s_if.ack = 1; s_if.rdata = 32'hCAFE0001;
    tick();
    s_if.ack = 0;
    chk("t3_m0_ack", m0_if.ack, 1);
    chk("t3_m0_data", m0_if.rdata, 32'hCAFE0001);

    m1_if.stb = 1; m1_if.addr = 32'h40;
    tick();
    m1_if.stb = 0;
    for (int k = 1; k < 15; k++) begin
      tick();
      chk("t4_m1_err_early", m1_if.err, 0);
    end
    tick();
    chk("t4_m1_err", m1_if.err, 1);
    chk("t4_m0_err", m0_if.err, 0);
    chk("t4_m1_ack", m1_if.ack, 0);
    chk("t4_s_stb", s_if.stb, 0);
    s_if.ack = 1; s_if.rdata = 32'h5555;
    tick();
    s_if.ack = 0;
    chk("t4_m1_err_pulse", m1_if.err, 0);
    chk("t4_stray_m0_ack", m0_if.ack, 0);
    chk("t4_stray_m1_ack", m1_if.ack, 0);

    m1_if.stb = 1; m1_if.we = 1; m1_if.addr = 32'h20; m1_if.wdata = 32'h1234; m1_if.sel = 3'b010;
    #1;
    chk("t5_m1_stall", m1_if.stall, 0);
    tick();
    m1_if.stb = 0; m1_if.wdata = 0; m1_if.we = 0;
    chk("t5_s_stb", s_if.stb, 1);
    chk("t5_s_we", s_if.we, 1);
    chk("t5_s_sel", s_if.sel, 3'b010);
    chk("t5_s_addr", s_if.addr, 32'h20);
    chk("t5_s_data", s_if.wdata, 32'h1234);
    tick();
    chk("t5_s_stb_wait", s_if.stb, 0);
    #2;
    rst_n = 0;
    s_if.ack = 1;
    #1;
    chk("t5_rst_s_we", s_if.we, 0);
    chk("t5_rst_s_addr", s_if.addr, 0);
    chk("t5_rst_s_data", s_if.wdata, 0);
    chk("t5_rst_s_sel", s_if.sel, 0);
    chk("t5_rst_m1_stall", m1_if.stall, 1);
    chk("t5_rst_m1_data", m1_if.rdata, 0);
    tick();
    rst_n = 1;
    s_if.ack = 0;
    tick();
    chk("t5_post_m1_ack", m1_if.ack, 0);
    chk("t5_post_m1_err", m1_if.err, 0);
    chk("t5_post_s_stb", s_if.stb, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
    $finish;
  end
endmodule
